ga_selection_ctrl: RTL and testbench

Parametrised successor of the GA selection FSM. Sequences the fitness→sorter channel, sorter drain to the sorted pool, parent selection and the final push to the output queue. Adds:
- a generation counter with automatic stop at a configured maximum generation count;
- a configurable number of parent-selection rounds per generation;
- a per-phase watchdog timeout with error recovery.

It sits between the GA top FSM, ga_fitness, the sorter and the parent selector.

---
 rtl/ga_selection_pkg.sv | 15 +
 rtl/ga_sel_watchdog.sv | 19 +
 rtl/ga_selection_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ga_selection_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ga_selection_pkg.sv
// ga_selection_pkg: shared state encoding and pool-source constants for the GA selection controller
package ga_selection_pkg;
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CHECK       = 3'd1,
        WR2POOL     = 3'd2,
        NEWGEN_RST  = 3'd3,
        SEL_PARENTS = 3'd4,
        PUSH2Q      = 3'd5,
        DONE_RST    = 3'd6,
        TMO_RST     = 3'd7
    } state_e;
    localparam logic SRC_SORTER  = 1'b0;
    localparam logic SRC_PARENTS = 1'b1;
endpackage

// File: rtl/ga_sel_watchdog.sv
// ga_sel_watchdog: phase watchdog counter; expires on the last counted cycle before the limit
module ga_sel_watchdog #(
    parameter int TMO_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [TMO_W-1:0] limit_i,
    output logic             expire_o
);
    logic [TMO_W-1:0] cnt_q, cnt_d;
    assign cnt_d    = clr_i ? '0 : en_i ? cnt_q + TMO_W'(1) : cnt_q;
    assign expire_o = en_i && (limit_i != '0) && (cnt_q == limit_i - TMO_W'(1));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ga_selection_ctrl.sv
// ga_selection_ctrl: sequences sorter fill/drain, parent rounds and output push with generation limit and watchdog
module ga_selection_ctrl
    import ga_selection_pkg::*;
#(
    parameter int GEN_W = 16,
    parameter int RND_W = 4,
    parameter int TMO_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sw_rst,
    input  logic [GEN_W-1:0] cfg_max_gens,
    input  logic [RND_W-1:0] cfg_parent_rounds,
    input  logic [TMO_W-1:0] cfg_tmo,
    input  logic             top_new_gen_req_pls,
    input  logic             top_stop_req_pls,
    input  logic             fit_valid,
    output logic             fit_ack,
    input  logic             sorter_ack,
    output logic             sorter_valid,
    input  logic             sorter_gen_created_pls,
    input  logic             sorter_send_all_done,
    input  logic             parents_done_pls,
    output logic             sorter_enable,
    output logic             sorter_get_all_start_req_pls,
    output logic             parents_start_pls,
    output logic             pool_mem_source_sel,
    output logic             push2queue_enable,
    output logic [GEN_W-1:0] gen_cnt,
    output logic             gen_ready_pls,
    output logic             auto_stop,
    output logic             tmo_err_pls,
    output logic             busy
);
    state_e           state_q, state_d;
    logic             chan_en_q, chan_en_d, sorter_en_q, sorter_en_d;
    logic             get_all_q, get_all_d, pstart_q, pstart_d;
    logic             sel_q, sel_d, push_q, push_d;
    logic             gen_ready_q, gen_ready_d, auto_stop_q, auto_stop_d;
    logic             tmo_err_q, tmo_err_d;
    logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
    logic [RND_W-1:0] round_q, round_d, rounds;
    logic             waiting, evt, wd_exp, lim_hit, more_rounds;

    assign rounds      = (cfg_parent_rounds == '0) ? RND_W'(1) : cfg_parent_rounds;
    assign more_rounds = ((RND_W+1)'(round_q) + (RND_W+1)'(1)) < (RND_W+1)'(rounds);
    assign lim_hit     = (cfg_max_gens != '0) &&
                         (((GEN_W+1)'(gen_cnt_q) + (GEN_W+1)'(1)) >= (GEN_W+1)'(cfg_max_gens));
    assign waiting     = (state_q == WR2POOL) || (state_q == SEL_PARENTS) || (state_q == PUSH2Q);
    assign evt         = (state_q == SEL_PARENTS) ? parents_done_pls :
                         waiting ? sorter_send_all_done : 1'b0;

    ga_sel_watchdog #(.TMO_W(TMO_W)) u_wd (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (sw_rst || (state_d != state_q)),
        .en_i     (waiting && !evt),
        .limit_i  (cfg_tmo),
        .expire_o (wd_exp)
    );

    always_comb begin
        state_d     = state_q;
        chan_en_d   = chan_en_q;
        sorter_en_d = sorter_en_q;
        get_all_d   = 1'b0;
        pstart_d    = 1'b0;
        sel_d       = sel_q;
        push_d      = push_q;
        gen_ready_d = sorter_gen_created_pls;
        auto_stop_d = auto_stop_q;
        tmo_err_d   = 1'b0;
        gen_cnt_d   = gen_cnt_q;
        round_d     = round_q;
        unique case (state_q)
            IDLE: if (sorter_gen_created_pls) begin
                state_d   = CHECK;
                chan_en_d = 1'b0;
            end
            CHECK: if (lim_hit || top_stop_req_pls) begin
                state_d     = PUSH2Q;
                get_all_d   = 1'b1;
                sel_d       = SRC_SORTER;
                push_d      = 1'b1;
                auto_stop_d = lim_hit;
            end else if (top_new_gen_req_pls) begin
                state_d   = WR2POOL;
                get_all_d = 1'b1;
                sel_d     = SRC_SORTER;
            end
            WR2POOL: if (sorter_send_all_done) begin
                state_d     = NEWGEN_RST;
                sorter_en_d = 1'b0;
            end
            NEWGEN_RST: begin
                state_d     = SEL_PARENTS;
                sorter_en_d = 1'b1;
                chan_en_d   = 1'b1;
                sel_d       = SRC_PARENTS;
                pstart_d    = 1'b1;
                round_d     = '0;
            end
            SEL_PARENTS: if (parents_done_pls) begin
                if (more_rounds) begin
                    round_d  = round_q + RND_W'(1);
                    pstart_d = 1'b1;
                end else begin
                    state_d   = IDLE;
                    sel_d     = SRC_SORTER;
                    gen_cnt_d = (gen_cnt_q == '1) ? gen_cnt_q : gen_cnt_q + GEN_W'(1);
                end
            end
            PUSH2Q: if (sorter_send_all_done) begin
                state_d     = DONE_RST;
                sorter_en_d = 1'b0;
                push_d      = 1'b0;
            end
            DONE_RST: begin
                state_d     = IDLE;
                sorter_en_d = 1'b1;
                chan_en_d   = 1'b1;
                auto_stop_d = 1'b0;
            end
            TMO_RST: begin
                state_d     = IDLE;
                sorter_en_d = 1'b1;
                chan_en_d   = 1'b1;
                auto_stop_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // the awaited event was handled above, so expiry only acts when it is absent
        if (wd_exp) begin
            state_d     = TMO_RST;
            tmo_err_d   = 1'b1;
            sorter_en_d = 1'b0;
            push_d      = 1'b0;
            sel_d       = SRC_SORTER;
            pstart_d    = 1'b0;
        end
        if (sw_rst) begin
            state_d     = IDLE;
            chan_en_d   = 1'b1;
            sorter_en_d = 1'b1;
            get_all_d   = 1'b0;
            pstart_d    = 1'b0;
            sel_d       = SRC_SORTER;
            push_d      = 1'b0;
            gen_ready_d = 1'b0;
            auto_stop_d = 1'b0;
            tmo_err_d   = 1'b0;
            gen_cnt_d   = '0;
            round_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            chan_en_q   <= 1'b1;
            sorter_en_q <= 1'b1;
            get_all_q   <= 1'b0;
            pstart_q    <= 1'b0;
            sel_q       <= SRC_SORTER;
            push_q      <= 1'b0;
            gen_ready_q <= 1'b0;
            auto_stop_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            gen_cnt_q   <= '0;
            round_q     <= '0;
        end else begin
            state_q     <= state_d;
            chan_en_q   <= chan_en_d;
            sorter_en_q <= sorter_en_d;
            get_all_q   <= get_all_d;
            pstart_q    <= pstart_d;
            sel_q       <= sel_d;
            push_q      <= push_d;
            gen_ready_q <= gen_ready_d;
            auto_stop_q <= auto_stop_d;
            tmo_err_q   <= tmo_err_d;
            gen_cnt_q   <= gen_cnt_d;
            round_q     <= round_d;
        end
    end

    assign fit_ack                      = sorter_ack && chan_en_q;
    assign sorter_valid                 = fit_valid && chan_en_q;
    assign sorter_enable                = sorter_en_q;
    assign sorter_get_all_start_req_pls = get_all_q;
    assign parents_start_pls            = pstart_q;
    assign pool_mem_source_sel          = sel_q;
    assign push2queue_enable            = push_q;
    assign gen_cnt                      = gen_cnt_q;
    assign gen_ready_pls                = gen_ready_q;
    assign auto_stop                    = auto_stop_q;
    assign tmo_err_pls                  = tmo_err_q;
    assign busy                         = state_q != IDLE;
endmodule

// File: tb/tb_ga_selection_ctrl.sv
// tb_ga_selection_ctrl: directed self-checking bench for ga_selection_ctrl
module tb_ga_selection_ctrl;
    logic        clk, rstn, sw_rst;
    logic [15:0] cfg_max_gens;
    logic [3:0]  cfg_parent_rounds;
    logic [11:0] cfg_tmo;
    logic        top_new_gen_req_pls, top_stop_req_pls, fit_valid, fit_ack, sorter_ack, sorter_valid;
    logic        sorter_gen_created_pls, sorter_send_all_done, parents_done_pls;
    logic        sorter_enable, sorter_get_all_start_req_pls, parents_start_pls, pool_mem_source_sel;
    logic        push2queue_enable, gen_ready_pls, auto_stop, tmo_err_pls, busy;
    logic [15:0] gen_cnt;
    int          vectors = 0, miscompares = 0, ps_cnt = 0, ga_cnt = 0;

    ga_selection_ctrl dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
        .cfg_max_gens(cfg_max_gens), .cfg_parent_rounds(cfg_parent_rounds), .cfg_tmo(cfg_tmo),
        .top_new_gen_req_pls(top_new_gen_req_pls), .top_stop_req_pls(top_stop_req_pls),
        .fit_valid(fit_valid), .fit_ack(fit_ack), .sorter_ack(sorter_ack), .sorter_valid(sorter_valid),
        .sorter_gen_created_pls(sorter_gen_created_pls), .sorter_send_all_done(sorter_send_all_done),
        .parents_done_pls(parents_done_pls), .sorter_enable(sorter_enable),
        .sorter_get_all_start_req_pls(sorter_get_all_start_req_pls),
        .parents_start_pls(parents_start_pls), .pool_mem_source_sel(pool_mem_source_sel),
        .push2queue_enable(push2queue_enable), .gen_cnt(gen_cnt), .gen_ready_pls(gen_ready_pls),
        .auto_stop(auto_stop), .tmo_err_pls(tmo_err_pls), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parents_start_pls) ps_cnt++;
        if (sorter_get_all_start_req_pls) ga_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; sw_rst = 1'b0;
        cfg_max_gens = 16'd2; cfg_parent_rounds = 4'd3; cfg_tmo = 12'd0;
        top_new_gen_req_pls = 1'b0; top_stop_req_pls = 1'b0;
        fit_valid = 1'b1; sorter_ack = 1'b1;
        sorter_gen_created_pls = 1'b0; sorter_send_all_done = 1'b0; parents_done_pls = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sorter_en", 32'(sorter_enable), 1);
        chk("rst_valid", 32'(sorter_valid), 1);
        chk("rst_ack", 32'(fit_ack), 1);
        chk("rst_gen_cnt", 32'(gen_cnt), 0);
        chk("rst_sel", 32'(pool_mem_source_sel), 0);
        chk("rst_push", 32'(push2queue_enable), 0);
        chk("rst_auto_stop", 32'(auto_stop), 0);

        // normal generation, three parent rounds, with channel gating
        ps_cnt = 0;
        sorter_gen_created_pls = 1'b1; tick(); sorter_gen_created_pls = 1'b0;
        chk("n_busy_check", 32'(busy), 1);
        chk("n_gen_ready", 32'(gen_ready_pls), 1);
        chk("n_valid_gated", 32'(sorter_valid), 0);
        chk("n_ack_gated", 32'(fit_ack), 0);
        tick();
        chk("n_gen_ready_drop", 32'(gen_ready_pls), 0);
        chk("n_wait_check", 32'(busy), 1);
        top_new_gen_req_pls = 1'b1; tick(); top_new_gen_req_pls = 1'b0;
        chk("n_get_all", 32'(sorter_get_all_start_req_pls), 1);
        chk("n_push_off", 32'(push2queue_enable), 0);
        tick();
        chk("n_get_all_drop", 32'(sorter_get_all_start_req_pls), 0);
        sorter_send_all_done = 1'b1; tick(); sorter_send_all_done = 1'b0;
        chk("n_newgen_sorter_en", 32'(sorter_enable), 0);
        chk("n_newgen_valid", 32'(sorter_valid), 0);
        tick();
        chk("n_sel_sorter_en", 32'(sorter_enable), 1);
        chk("n_sel_valid", 32'(sorter_valid), 1);
        chk("n_sel_src", 32'(pool_mem_source_sel), 1);
        chk("n_pstart0", 32'(parents_start_pls), 1);
        tick();
        chk("n_pstart0_drop", 32'(parents_start_pls), 0);
        parents_done_pls = 1'b1; tick(); parents_done_pls = 1'b0;
        chk("n_pstart1", 32'(parents_start_pls), 1);
        chk("n_sel_r1", 32'(pool_mem_source_sel), 1);
        tick();
        parents_done_pls = 1'b1; tick(); parents_done_pls = 1'b0;
        chk("n_pstart2", 32'(parents_start_pls), 1);
        chk("n_sel_r2", 32'(pool_mem_source_sel), 1);
        tick();
        parents_done_pls = 1'b1; tick(); parents_done_pls = 1'b0;
        chk("n_idle", 32'(busy), 0);
        chk("n_no_pstart", 32'(parents_start_pls), 0);
        chk("n_sel_back", 32'(pool_mem_source_sel), 0);
        chk("n_gen_cnt", 32'(gen_cnt), 1);
        chk("n_pstart_total", 32'(ps_cnt), 3);
        parents_done_pls = 1'b1; tick(); parents_done_pls = 1'b0;
        chk("stray_busy", 32'(busy), 0);
        chk("stray_pstart", 32'(parents_start_pls), 0);

        // auto-stop on the second generation
        sorter_gen_created_pls = 1'b1; tick(); sorter_gen_created_pls = 1'b0;
        tick();
        chk("a_get_all", 32'(sorter_get_all_start_req_pls), 1);
        chk("a_push", 32'(push2queue_enable), 1);
        chk("a_auto_stop", 32'(auto_stop), 1);
        chk("a_sel", 32'(pool_mem_source_sel), 0);
        repeat (3) tick();
        chk("a_push_hold", 32'(push2queue_enable), 1);
        sorter_send_all_done = 1'b1; tick(); sorter_send_all_done = 1'b0;
        chk("a_done_push", 32'(push2queue_enable), 0);
        chk("a_done_sorter_en", 32'(sorter_enable), 0);
        chk("a_done_auto", 32'(auto_stop), 1);
        tick();
        chk("a_idle", 32'(busy), 0);
        chk("a_auto_clr", 32'(auto_stop), 0);
        chk("a_sorter_en", 32'(sorter_enable), 1);
        chk("a_gen_cnt", 32'(gen_cnt), 1);

        // stop and new-gen together: stop wins
        cfg_max_gens = 16'd0; ga_cnt = 0;
        sorter_gen_created_pls = 1'b1; tick(); sorter_gen_created_pls = 1'b0;
        top_new_gen_req_pls = 1'b1; top_stop_req_pls = 1'b1; tick();
        top_new_gen_req_pls = 1'b0; top_stop_req_pls = 1'b0;
        chk("s_push", 32'(push2queue_enable), 1);
        chk("s_auto_stop", 32'(auto_stop), 0);
        repeat (2) tick();
        chk("s_get_all_total", 32'(ga_cnt), 1);
        sorter_send_all_done = 1'b1; tick(); sorter_send_all_done = 1'b0;
        tick();
        chk("s_idle", 32'(busy), 0);
        chk("s_gen_cnt", 32'(gen_cnt), 1);

        // watchdog while waiting for the drain
        cfg_tmo = 12'd8;
        sorter_gen_created_pls = 1'b1; tick(); sorter_gen_created_pls = 1'b0;
        top_new_gen_req_pls = 1'b1; tick(); top_new_gen_req_pls = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("w_quiet%0d", i), 32'(tmo_err_pls), 0);
        end
        tick();
        chk("w_tmo", 32'(tmo_err_pls), 1);
        chk("w_sorter_off", 32'(sorter_enable), 0);
        tick();
        chk("w_tmo_drop", 32'(tmo_err_pls), 0);
        chk("w_sorter_on", 32'(sorter_enable), 1);
        chk("w_idle", 32'(busy), 0);
        chk("w_valid", 32'(sorter_valid), 1);
        chk("w_gen_cnt", 32'(gen_cnt), 1);

        // soft reset in the middle of parent selection
        cfg_tmo = 12'd0;
        sorter_gen_created_pls = 1'b1; tick(); sorter_gen_created_pls = 1'b0;
        top_new_gen_req_pls = 1'b1; tick(); top_new_gen_req_pls = 1'b0;
        sorter_send_all_done = 1'b1; tick(); sorter_send_all_done = 1'b0;
        tick();
        chk("r_in_sel", 32'(pool_mem_source_sel), 1);
        sw_rst = 1'b1; parents_done_pls = 1'b1; tick();
        sw_rst = 1'b0; parents_done_pls = 1'b0;
        chk("r_idle", 32'(busy), 0);
        chk("r_sel", 32'(pool_mem_source_sel), 0);
        chk("r_pstart", 32'(parents_start_pls), 0);
        chk("r_gen_cnt", 32'(gen_cnt), 0);
        chk("r_sorter_en", 32'(sorter_enable), 1);
        chk("r_valid", 32'(sorter_valid), 1);
        chk("r_push", 32'(push2queue_enable), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
